// File: rtl/reg_file_sync_if.sv
// ============================================================================
// Module : reg_file_sync_if
// Brief  : Write, read and clear signal bundle for reg_file_sync.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_file_sync_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) ();
   logic                  Reg_Write_i;
   logic [ADDR_WIDTH-1:0] Write_Register_i;
   logic [DATA_WIDTH-1:0] Write_Data_i;
   logic                  Read_En_i;
   logic [ADDR_WIDTH-1:0] Read_Register_1_i;
   logic [ADDR_WIDTH-1:0] Read_Register_2_i;
   logic [DATA_WIDTH-1:0] Read_Data_1_o;
   logic [DATA_WIDTH-1:0] Read_Data_2_o;
   logic                  Read_Valid_o;
   logic                  Clear_Req_i;
   logic                  Busy_o;

   modport master (
      output Reg_Write_i, Write_Register_i, Write_Data_i,
      output Read_En_i, Read_Register_1_i, Read_Register_2_i, Clear_Req_i,
      input  Read_Data_1_o, Read_Data_2_o, Read_Valid_o, Busy_o
   );

   modport slave (
      input  Reg_Write_i, Write_Register_i, Write_Data_i,
      input  Read_En_i, Read_Register_1_i, Read_Register_2_i, Clear_Req_i,
      output Read_Data_1_o, Read_Data_2_o, Read_Valid_o, Busy_o
   );
endinterface

`default_nettype wire

// File: rtl/reg_file_sync.sv
// ============================================================================
// Module : reg_file_sync
// Brief  : Parametrised register file, two registered read ports, sequential
//          clear engine. Optional macro REG_FILE_BYPASS_EN enables write-first
//          forwarding on same-cycle read/write collisions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_file_sync #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 1
) (
   input  wire logic     clk,
   input  wire logic     reset,
   reg_file_sync_if.slave bus
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   localparam logic [ADDR_WIDTH:0] c_num_regs = (ADDR_WIDTH+1)'(NUM_REGS);
   localparam logic [ADDR_WIDTH:0] c_last_idx = (ADDR_WIDTH+1)'(NUM_REGS - 1);

   logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
   logic [0:0]            r_state;
   logic [ADDR_WIDTH:0]   r_idx;
   logic [DATA_WIDTH-1:0] r_rd_data_1;
   logic [DATA_WIDTH-1:0] r_rd_data_2;
   logic                  r_rd_valid;

   logic                  w_idle;
   logic                  w_wr_ok;
   logic [DATA_WIDTH-1:0] w_rd_data_1;
   logic [DATA_WIDTH-1:0] w_rd_data_2;

   assign w_idle  = (r_state == S_IDLE);
   // Writable target: in range and not the hardwired zero register
   assign w_wr_ok = w_idle && bus.Reg_Write_i
                    && ({1'b0, bus.Write_Register_i} < c_num_regs)
                    && !((ZERO_REG != 0) && (bus.Write_Register_i == '0));

   always_comb begin
      w_rd_data_1 = r_regs[bus.Read_Register_1_i];
      if (({1'b0, bus.Read_Register_1_i} >= c_num_regs)
          || ((ZERO_REG != 0) && (bus.Read_Register_1_i == '0)))
         w_rd_data_1 = '0;
`ifdef REG_FILE_BYPASS_EN
      else if (w_wr_ok && (bus.Read_Register_1_i == bus.Write_Register_i))
         w_rd_data_1 = bus.Write_Data_i;
`endif
   end

   always_comb begin
      w_rd_data_2 = r_regs[bus.Read_Register_2_i];
      if (({1'b0, bus.Read_Register_2_i} >= c_num_regs)
          || ((ZERO_REG != 0) && (bus.Read_Register_2_i == '0)))
         w_rd_data_2 = '0;
`ifdef REG_FILE_BYPASS_EN
      else if (w_wr_ok && (bus.Read_Register_2_i == bus.Write_Register_i))
         w_rd_data_2 = bus.Write_Data_i;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_rd_data_1 <= '0;
         r_rd_data_2 <= '0;
         r_rd_valid  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_wr_ok) r_regs[bus.Write_Register_i] <= bus.Write_Data_i;
               r_rd_valid <= bus.Read_En_i;
               if (bus.Read_En_i) begin
                  r_rd_data_1 <= w_rd_data_1;
                  r_rd_data_2 <= w_rd_data_2;
               end
               if (bus.Clear_Req_i) begin
                  r_state <= S_CLEAR;
                  r_idx   <= '0;
               end
            end
            default: begin
               // One register per cycle; all bus requests dropped meanwhile
               r_regs[r_idx[ADDR_WIDTH-1:0]] <= '0;
               r_rd_valid <= 1'b0;
               r_idx      <= r_idx + 1'b1;
               if (r_idx == c_last_idx) r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.Read_Data_1_o = r_rd_data_1;
   assign bus.Read_Data_2_o = r_rd_data_2;
   assign bus.Read_Valid_o  = r_rd_valid;
   assign bus.Busy_o        = (r_state == S_CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sync.sv
// ============================================================================
// Module : tb_reg_file_sync
// Brief  : Directed bench driving three reg_file_sync configurations in step.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sync;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr, ren, clr;
   logic [4:0]  waddr, ra1, ra2;
   logic [31:0] wdata;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   // a: 32 regs, zero reg; b: 32 regs, ordinary reg0; c: 24 regs, zero reg
   reg_file_sync_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus_a ();
   reg_file_sync_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus_b ();
   reg_file_sync_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus_c ();

   assign bus_a.Reg_Write_i = wr;  assign bus_b.Reg_Write_i = wr;  assign bus_c.Reg_Write_i = wr;
   assign bus_a.Write_Register_i = waddr; assign bus_b.Write_Register_i = waddr; assign bus_c.Write_Register_i = waddr;
   assign bus_a.Write_Data_i = wdata; assign bus_b.Write_Data_i = wdata; assign bus_c.Write_Data_i = wdata;
   assign bus_a.Read_En_i = ren;   assign bus_b.Read_En_i = ren;   assign bus_c.Read_En_i = ren;
   assign bus_a.Read_Register_1_i = ra1; assign bus_b.Read_Register_1_i = ra1; assign bus_c.Read_Register_1_i = ra1;
   assign bus_a.Read_Register_2_i = ra2; assign bus_b.Read_Register_2_i = ra2; assign bus_c.Read_Register_2_i = ra2;
   assign bus_a.Clear_Req_i = clr; assign bus_b.Clear_Req_i = clr; assign bus_c.Clear_Req_i = clr;

   reg_file_sync #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .ZERO_REG(1))
      u_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
   reg_file_sync #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .ZERO_REG(0))
      u_b (.clk(clk), .reset(reset), .bus(bus_b.slave));
   reg_file_sync #(.DATA_WIDTH(32), .NUM_REGS(24), .ADDR_WIDTH(5), .ZERO_REG(1))
      u_c (.clk(clk), .reset(reset), .bus(bus_c.slave));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
      wr = 1'b1; waddr = a; wdata = d;
      tick();
      wr = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
      ren = 1'b1; ra1 = a1; ra2 = a2;
      tick();
      ren = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_byp;
      reset = 1'b1; wr = 1'b0; ren = 1'b0; clr = 1'b0;
      waddr = '0; ra1 = '0; ra2 = '0; wdata = '0;
      tick(); tick();
      check("reset_rd1",   bus_a.Read_Data_1_o, 32'h0);
      check("reset_rd2",   bus_a.Read_Data_2_o, 32'h0);
      check("reset_valid", {31'b0, bus_a.Read_Valid_o}, 32'h0);
      check("reset_busy",  {31'b0, bus_a.Busy_o}, 32'h0);
      reset = 1'b0;

      wr_reg(2, 7); wr_reg(4, 20); wr_reg(25, 6); wr_reg(31, 78);
      rd(2, 4);
      check("rd_2_4_valid", {31'b0, bus_a.Read_Valid_o}, 32'h1);
      check("rd_2",  bus_a.Read_Data_1_o, 32'd7);
      check("rd_4",  bus_a.Read_Data_2_o, 32'd20);
      rd(25, 31);
      check("rd_25", bus_a.Read_Data_1_o, 32'd6);
      check("rd_31", bus_a.Read_Data_2_o, 32'd78);
      check("c_rd_25_oob", bus_c.Read_Data_1_o, 32'h0);
      check("c_rd_31_oob", bus_c.Read_Data_2_o, 32'h0);
      tick();
      check("valid_drop", {31'b0, bus_a.Read_Valid_o}, 32'h0);
      check("hold_rd1",   bus_a.Read_Data_1_o, 32'd6);

      // reg0: same-cycle write and read, then a read one cycle later
`ifdef REG_FILE_BYPASS_EN
      exp_byp = 32'hFFFF_FFFF;
`else
      exp_byp = 32'h0;
`endif
      wr = 1'b1; waddr = 0; wdata = 32'hFFFF_FFFF; ren = 1'b1; ra1 = 0; ra2 = 2;
      tick();
      wr = 1'b0; ren = 1'b0;
      check("a_reg0_collide", bus_a.Read_Data_1_o, 32'h0);
      check("b_reg0_collide", bus_b.Read_Data_1_o, exp_byp);
      rd(0, 2);
      check("a_reg0_zero", bus_a.Read_Data_1_o, 32'h0);
      check("b_reg0_ord",  bus_b.Read_Data_1_o, 32'hFFFF_FFFF);

`ifdef REG_FILE_BYPASS_EN
      exp_byp = 32'h1234;
`else
      exp_byp = 32'h55;
`endif
      wr_reg(5, 32'h55);
      wr = 1'b1; waddr = 5; wdata = 32'h1234; ren = 1'b1; ra1 = 5; ra2 = 4;
      tick();
      wr = 1'b0; ren = 1'b0;
      check("collide_rd5", bus_a.Read_Data_1_o, exp_byp);
      check("collide_rd4", bus_a.Read_Data_2_o, 32'd20);
      rd(5, 5);
      check("late_rd5_p1", bus_a.Read_Data_1_o, 32'h1234);
      check("late_rd5_p2", bus_a.Read_Data_2_o, 32'h1234);

      wr_reg(30, 32'hAA); wr_reg(23, 32'h17);
      rd(30, 23);
      check("c_rd30_oob", bus_c.Read_Data_1_o, 32'h0);
      check("c_rd23",     bus_c.Read_Data_2_o, 32'h17);

      for (int i = 0; i < 32; i++) wr_reg(5'(i), 32'(i + 1));
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int k = 0; k < 32; k++) begin
         check($sformatf("clr_busy_%0d", k), {31'b0, bus_a.Busy_o}, 32'h1);
         check($sformatf("clr_valid_%0d", k), {31'b0, bus_a.Read_Valid_o}, 32'h0);
         wr = (k < 30); ren = (k < 30); waddr = 7; wdata = 32'hDEAD; ra1 = 7; ra2 = 8;
         tick();
      end
      wr = 1'b0; ren = 1'b0;
      check("clr_busy_end", {31'b0, bus_a.Busy_o}, 32'h0);
      for (int i = 0; i < 16; i++) begin
         rd(5'(2 * i), 5'(2 * i + 1));
         check($sformatf("cleared_%0d", 2 * i),     bus_a.Read_Data_1_o, 32'h0);
         check($sformatf("cleared_%0d", 2 * i + 1), bus_a.Read_Data_2_o, 32'h0);
      end

      wr_reg(3, 5);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clr2_busy", {31'b0, bus_a.Busy_o}, 32'h1);
      repeat (9) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("abort_busy",  {31'b0, bus_a.Busy_o}, 32'h0);
      check("abort_valid", {31'b0, bus_a.Read_Valid_o}, 32'h0);
      wr_reg(3, 9);
      rd(3, 20);
      check("abort_rd3",  bus_a.Read_Data_1_o, 32'd9);
      check("abort_rd20", bus_a.Read_Data_2_o, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/reg_file_sync.md
Name: reg_file_sync

Overview:
Next-generation general-purpose register file for the single-cycle/pipelined core datapath, replacing the fixed 32x32 asynchronous-read file.
- Parametrised in data width and register count.
- Two registered read ports with one-cycle latency and a read-valid strobe.
- Register 0 optionally hardwired to zero.
- Sequential clear engine that zeroes the file on request without a global reset.

Parameters:
DATA_WIDTH, 32, width of each register and of the data ports
NUM_REGS, 32, number of registers; any value from 2 to 2**ADDR_WIDTH
ADDR_WIDTH, 5, width of register address ports
ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes; 0 = register 0 is ordinary

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
Reg_Write_i  input  1  write enable
Write_Register_i  input  ADDR_WIDTH  write address
Write_Data_i  input  DATA_WIDTH  write data
Read_En_i  input  1  read request for both ports this cycle
Read_Register_1_i  input  ADDR_WIDTH  read address, port 1
Read_Register_2_i  input  ADDR_WIDTH  read address, port 2
Read_Data_1_o  output  DATA_WIDTH  registered read data, port 1
Read_Data_2_o  output  DATA_WIDTH  registered read data, port 2
Read_Valid_o  output  1  read data valid, one cycle after an accepted Read_En_i
Clear_Req_i  input  1  start sequential clear of the whole file
Busy_o  output  1  clear engine active

Behaviour:
Reset
- Reset is synchronous and active-high on clk.
- Reset zeroes all registers, Read_Data_1_o, Read_Data_2_o, Read_Valid_o and Busy_o.
- FSM goes to IDLE and the clear index goes to 0.
- Reset mid-clear aborts the clear. The result is the same, because reset zeroes everything.

FSM states
- IDLE: normal operation.
  - Clear_Req_i=1 moves to CLEAR next cycle, with index=0 and Busy_o=1 from that cycle.
  - A Reg_Write_i or Read_En_i arriving in the same cycle as Clear_Req_i is still serviced normally.
- CLEAR: each cycle, register[index] <= 0 and index increments.
  - After index reaches NUM_REGS-1, returns to IDLE. Busy_o drops in the first IDLE cycle.
  - Clear takes exactly NUM_REGS cycles.
  - In CLEAR, Reg_Write_i is ignored, Read_En_i is ignored (Read_Valid_o stays 0), and Clear_Req_i is ignored.

Writes
- When Reg_Write_i=1 in IDLE, register[Write_Register_i] <= Write_Data_i at the rising edge.
- Writes are ignored if the address is >= NUM_REGS.
- Writes are ignored if the address is 0 and ZERO_REG=1.

Reads
- When Read_En_i=1 in IDLE, at the next edge:
  - Read_Data_n_o <= register[Read_Register_n_i].
  - Read_Valid_o <= 1.
- Outputs hold their value when Read_En_i=0. Read_Valid_o is 1 only for the cycle following the request.
- An address >= NUM_REGS returns 0.
- Address 0 with ZERO_REG=1 returns 0.
- Both ports may read the same address.
- Read/write same-address collision in the same cycle is governed by the optional feature.

Widths
- No arithmetic beyond the clear index counter (ADDR_WIDTH+1 bits, no wrap inside a clear).

Optional Feature:
Macro: REG_FILE_BYPASS_EN
- Defined: a same-cycle read and write to the same valid, writable address returns Write_Data_i on that read port (write-first).
- Defined: a write to register 0 with ZERO_REG=1 is not forwarded; the read returns 0.
- Not defined: such a read returns the pre-write content (read-first). The new value is visible to reads issued one cycle later.

Test Plan:
- Reset, then write reg2=7, reg4=20, reg25=6, reg31=78 on consecutive cycles, then read ports (2,4), then (25,31) -> Read_Data pairs 7/20 then 6/78, each one cycle after Read_En_i with Read_Valid_o=1 for that cycle.
- With ZERO_REG=1, write reg0=0xFFFFFFFF, then read port1=0 -> 0. With ZERO_REG=0, same sequence -> 0xFFFFFFFF.
- Same-cycle write reg5=0x1234 and read reg5 (reg5 previously 0x55) -> 0x1234 with REG_FILE_BYPASS_EN, 0x55 without. Read issued next cycle -> 0x1234 in both builds.
- Fill all 32 registers with their index+1, pulse Clear_Req_i -> Busy_o high for exactly 32 cycles. During clear, writes and reads are ignored (Read_Valid_o=0). After Busy_o falls, reading any register returns 0.
- Start a clear, assert reset at clear cycle 10 -> Busy_o=0 and FSM in IDLE next cycle. A write of reg3=9 then a read -> 9.
- NUM_REGS=24: write reg30=0xAA, then read reg30 and reg23 (previously written 0x17) -> 0 and 0x17.
